// File: rtl/button_debouncer.sv
// ----------------------------------------------------------------------------
// button_debouncer
//
// Turns a raw, bouncing, asynchronous push-button (or select) pin into clean
// events in the clk domain: a debounced level, one-cycle press / release /
// long-press strobes, a toggle flag and an 8-bit wrapping press counter.
//
// Parameters
//   LOG2DELAY      input must be stable for 2^LOG2DELAY consecutive cycles
//   LONGPRESS_LOG2 long-press threshold, 2^LONGPRESS_LOG2 cycles held
//   ACTIVE_LOW     1 = pin reads low when pressed
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous, active-high reset
//   btn_in         raw button pin (asynchronous)
//   btn_level      debounced pressed level
//   press_pulse    one-cycle strobe on debounced press
//   release_pulse  one-cycle strobe on debounced release
//   long_pulse     one-cycle strobe when a hold reaches the long threshold
//   toggle         flips on every debounced press
//   press_count    number of debounced presses, wraps at 256
// ----------------------------------------------------------------------------
module button_debouncer #(
    parameter int LOG2DELAY      = 16,
    parameter int LONGPRESS_LOG2 = 23,
    parameter bit ACTIVE_LOW     = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       toggle,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [LOG2DELAY-1:0]      CNT_MAX  = '1;
    localparam logic [LOG2DELAY-1:0]      CNT_ONE  = {{(LOG2DELAY-1){1'b0}}, 1'b1};
    localparam logic [LONGPRESS_LOG2-1:0] LONG_MAX = '1;
    localparam logic [LONGPRESS_LOG2-1:0] LONG_ONE = {{(LONGPRESS_LOG2-1){1'b0}}, 1'b1};

    state_t                    state;
    logic [LOG2DELAY-1:0]      cnt;
    logic [LONGPRESS_LOG2-1:0] long_cnt;
    logic                      long_done;

    // Normalise polarity before the synchroniser so everything downstream
    // works in "1 = pressed" terms.
    logic p;
    assign p = btn_in ^ ACTIVE_LOW;

    // Two-flop synchroniser; sync_pipe[1] is the only copy the FSM may look at.
    logic [1:0] sync_pipe;
    logic       s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_pipe <= 2'b00;
        end else begin
            sync_pipe <= {sync_pipe[0], p};
        end
    end

    assign s2 = sync_pipe[1];

    // Debounce FSM with registered outputs. The debounce counter is cleared on
    // every entry to a wait state, so it never needs to wrap. The long-press
    // counter and long_done survive a release bounce (RELEASE_WAIT back to
    // PRESSED) so one physical hold gives at most one long_pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            long_cnt      <= '0;
            long_done     <= 1'b0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            toggle        <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;

            case (state)
                IDLE: begin
                    if (s2) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end

                PRESS_WAIT: begin
                    if (!s2) begin
                        // bounce: drop back silently
                        state <= IDLE;
                    end else if (cnt == CNT_MAX) begin
                        state       <= PRESSED;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
                        toggle      <= ~toggle;
                        press_count <= press_count + 8'd1;
                        long_cnt    <= '0;
                        long_done   <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                PRESSED: begin
                    if (!s2) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end else if (!long_done) begin
                        if (long_cnt == LONG_MAX) begin
                            long_pulse <= 1'b1;
                            long_done  <= 1'b1;
                        end else begin
                            long_cnt <= long_cnt + LONG_ONE;
                        end
                    end
                end

                RELEASE_WAIT: begin
                    if (s2) begin
                        // release bounce: resume the hold without any strobe
                        state <= PRESSED;
                    end else if (cnt == CNT_MAX) begin
                        state         <= IDLE;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Input-side counterpart to the LED pattern top: conditions a raw, bouncing, asynchronous push-button or select line (e.g. `sel`) into clean, clock-synchronous events.
- Provides a debounced level, one-cycle press/release/long-press strobes, a toggle flag and an 8-bit press counter.
- Sits between the board pin and any pattern/mode logic on the iCE40 HX8K clock domain.

Parameters:
- LOG2DELAY, 16, debounce window: the input must be stable for 2^LOG2DELAY consecutive cycles.
- LONGPRESS_LOG2, 23, long-press threshold: 2^LONGPRESS_LOG2 cycles held in PRESSED.
- ACTIVE_LOW, 0, when 1 the pin is inverted before synchronisation (pressed = pin low).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn_in  input  1  raw asynchronous button/select pin.
- btn_level  output  1  debounced pressed level.
- press_pulse  output  1  one-cycle strobe on debounced press.
- release_pulse  output  1  one-cycle strobe on debounced release.
- long_pulse  output  1  one-cycle strobe when hold reaches the long-press threshold.
- toggle  output  1  flips on every debounced press.
- press_count  output  8  count of debounced presses; wraps.

Behaviour:
- Input path:
  - p = btn_in XOR ACTIVE_LOW.
  - Two-flop synchroniser s1 -> s2; only s2 is used downstream.
  - s1 and s2 reset to 0.
- Reset (async, rst=1):
  - state=IDLE; debounce counter, long counter and long_done all cleared.
  - btn_level, press_pulse, release_pulse, long_pulse, toggle all 0; press_count=0.
  - Takes effect immediately, including mid-debounce or mid-hold.
  - If the button is held when rst deasserts, a full debounce is run and press_pulse is generated normally.
- Debounce counter `cnt`: LOG2DELAY bits; "expired" means cnt == all-ones while the awaited level is sampled.
- FSM states and transitions:
  - IDLE: s2=1 -> PRESS_WAIT, cnt<=0.
  - PRESS_WAIT:
    - s2=0 -> IDLE (bounce rejected, no output).
    - s2=1 and cnt==all-ones -> PRESSED, with btn_level<=1, press_pulse<=1, toggle<=~toggle, press_count<=press_count+1 (255 -> 0), long counter<=0, long_done<=0.
    - Otherwise cnt<=cnt+1.
  - PRESSED:
    - s2=0 -> RELEASE_WAIT, cnt<=0.
    - Otherwise, if long_done=0, long counter increments; when it is all-ones: long_pulse<=1, long_done<=1, counter stops.
    - At most one long_pulse per press.
  - RELEASE_WAIT:
    - s2=1 -> PRESSED. This is a release bounce: no strobes; long counter and long_done are retained, so no second long_pulse.
    - s2=0 and cnt==all-ones -> IDLE, with btn_level<=0, release_pulse<=1.
    - Otherwise cnt<=cnt+1.
- Outputs:
  - All outputs are registered.
  - Strobes are high for exactly one cycle, then return to 0.
  - press_pulse and release_pulse are never high together.
  - long_pulse cannot coincide with press_pulse.
- Latency:
  - With btn_in clean-high from rising edge 1, press_pulse is high in the cycle after edge 2^LOG2DELAY+3; btn_level rises on the same edge.
  - Release is symmetric: release_pulse follows edge 2^LOG2DELAY+3 counted from the first edge sampling btn_in low.
- Glitch rejection: any pulse on s2 shorter than 2^LOG2DELAY+1 cycles in either wait state causes no output change.
- Counters wrap only where stated; the debounce counter never wraps because it is cleared on every transition.

Test Plan:
- LOG2DELAY=4, LONGPRESS_LOG2=6. Assert rst async mid-cycle -> all outputs 0 immediately. Release rst with btn_in=0 -> outputs stay 0 for 100 cycles.
- Clean press: btn_in 0->1 held -> press_pulse high for exactly 1 cycle after edge 19 (2^4+3); btn_level=1 and toggle=1 on the same edge; press_count=1.
- Bounce: btn_in toggled 1/0 every 5 cycles for 60 cycles, then held high -> no output during the bounce; exactly one press_pulse 19 edges after the final rising edge; press_count increments by exactly 1.
- Long press: hold 200 cycles -> one long_pulse 64 cycles after the press_pulse edge. Then a 3-cycle low glitch mid-hold -> no release_pulse and no second long_pulse. Final release -> release_pulse 19 edges later, btn_level=0.
- Wrap and toggle: 256 debounced presses -> press_count returns to 0; toggle=0 after an even count. Also ACTIVE_LOW=1 with btn_in idle high -> no events; driving btn_in low -> press_pulse.
- Reset mid-hold: assert rst during PRESSED with btn_in still high -> btn_level=0 immediately. After deassert -> a fresh press_pulse 19 edges later, press_count=1.
